// File: rtl/issue_select_pipe.sv
// rtl/issue_select_pipe.sv - oldest-first multi-class issue selector with registered issue slots
// Optional ISSUE_PERF_CNT_EN adds perf_issued/perf_stall counters.
module issue_select_pipe #(
  parameter int RS_DEPTH  = 16,
  parameter int ISSUE_W   = 3,
  parameter int NUM_CLASS = 4,
  parameter int AGE_W     = 6,
  parameter int CNT_W     = 3
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   mispredict,
  input  logic [RS_DEPTH-1:0]                    ent_valid,
  input  logic [RS_DEPTH-1:0]                    ent_ready,
  input  logic [RS_DEPTH*$clog2(NUM_CLASS)-1:0]  ent_class,
  input  logic [RS_DEPTH*AGE_W-1:0]              ent_age,
  input  logic [AGE_W-1:0]                       head_age,
  input  logic [NUM_CLASS*CNT_W-1:0]             fu_free_cnt,
  input  logic                                   out_ready,
  output logic [ISSUE_W-1:0]                     clear_valid,
  output logic [ISSUE_W*$clog2(RS_DEPTH)-1:0]    clear_idx,
  output logic [ISSUE_W-1:0]                     issue_valid,
  output logic [ISSUE_W*$clog2(RS_DEPTH)-1:0]    issue_idx,
  output logic [ISSUE_W*$clog2(NUM_CLASS)-1:0]   issue_class
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                            perf_issued,
  output logic [31:0]                            perf_stall
`endif
);

  localparam int CLS_W = $clog2(NUM_CLASS);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [AGE_W-1:0]    rel     [RS_DEPTH];
  logic [CLS_W-1:0]    cls     [RS_DEPTH];
  logic [RS_DEPTH-1:0] older_m [RS_DEPTH];
  int                  slot    [RS_DEPTH];
  logic [RS_DEPTH-1:0] cand, class_ok, grant_ok;

  logic [ISSUE_W-1:0]       gnt_valid;
  logic [ISSUE_W*IDX_W-1:0] gnt_idx;
  logic [ISSUE_W*CLS_W-1:0] gnt_cls;
  logic                     stall;

  logic [ISSUE_W-1:0]       issue_valid_q, issue_valid_d;
  logic [ISSUE_W*IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic [ISSUE_W*CLS_W-1:0] issue_class_q, issue_class_d;

  // Age relative to the ROB head makes the wrap bit irrelevant to ordering.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      cand[i] = ent_valid[i] & ent_ready[i] & ~mispredict;
      rel[i]  = ent_age[i*AGE_W +: AGE_W] - head_age;
      cls[i]  = ent_class[i*CLS_W +: CLS_W];
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        older_m[i][j] = cand[j] && ((rel[j] < rel[i]) || ((rel[j] == rel[i]) && (j < i)));
      end
    end
  end

  // A class cap only depends on older same-class candidates, so each entry
  // resolves its grant and slot in parallel instead of a serial scan.
  always_comb begin
    int n_same;
    int n_ok;
    for (int i = 0; i < RS_DEPTH; i++) begin
      n_same = 0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (older_m[i][j] && (cls[j] == cls[i])) n_same++;
      end
      class_ok[i] = cand[i] && (n_same < int'(fu_free_cnt[cls[i]*CNT_W +: CNT_W]));
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      n_ok = 0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (older_m[i][j] && class_ok[j]) n_ok++;
      end
      slot[i]     = n_ok;
      grant_ok[i] = class_ok[i] && (n_ok < ISSUE_W);
    end
  end

  always_comb begin
    gnt_valid = '0;
    gnt_idx   = '0;
    gnt_cls   = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (grant_ok[i] && (slot[i] == k)) begin
          gnt_valid[k]                 = 1'b1;
          gnt_idx[k*IDX_W +: IDX_W]    = IDX_W'(i);
          gnt_cls[k*CLS_W +: CLS_W]    = cls[i];
        end
      end
    end
  end

  assign stall = (|issue_valid_q) & ~out_ready;

  always_comb begin
    clear_valid = '0;
    clear_idx   = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      clear_valid[k] = gnt_valid[k] & ~stall & ~mispredict & ~reset;
      if (clear_valid[k]) clear_idx[k*IDX_W +: IDX_W] = gnt_idx[k*IDX_W +: IDX_W];
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    issue_class_d = issue_class_q;
    if (mispredict) begin
      issue_valid_d = '0;
    end else if (!stall) begin
      issue_valid_d = gnt_valid;
      issue_idx_d   = gnt_idx;
      issue_class_d = gnt_cls;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      issue_class_q <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      issue_class_q <= issue_class_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;
  assign issue_class = issue_class_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] n_clear;

  always_comb begin
    n_clear = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      n_clear = n_clear + {31'd0, clear_valid[k]};
    end
    perf_issued_d = perf_issued_q + n_clear;
    perf_stall_d  = perf_stall_q + {31'd0, stall};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_select_pipe.sv
// tb/tb_issue_select_pipe.sv - directed self-checking bench for issue_select_pipe
module tb_issue_select_pipe;

  logic         clock;
  logic         reset;
  logic         mispredict;
  logic [15:0]  ent_valid;
  logic [15:0]  ent_ready;
  logic [31:0]  ent_class;
  logic [95:0]  ent_age;
  logic [5:0]   head_age;
  logic [11:0]  fu_free_cnt;
  logic         out_ready;
  logic [2:0]   clear_valid;
  logic [11:0]  clear_idx;
  logic [2:0]   issue_valid;
  logic [11:0]  issue_idx;
  logic [5:0]   issue_class;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]  perf_issued;
  logic [31:0]  perf_stall;
`endif

  int nchk = 0;
  int nerr = 0;

  issue_select_pipe dut (
    .clock       (clock),
    .reset       (reset),
    .mispredict  (mispredict),
    .ent_valid   (ent_valid),
    .ent_ready   (ent_ready),
    .ent_class   (ent_class),
    .ent_age     (ent_age),
    .head_age    (head_age),
    .fu_free_cnt (fu_free_cnt),
    .out_ready   (out_ready),
    .clear_valid (clear_valid),
    .clear_idx   (clear_idx),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_class (issue_class)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_all();
    ent_valid = '0;
    ent_ready = '0;
    ent_class = '0;
    ent_age   = '0;
  endtask

  task automatic set_ent(input int i, input int c, input int a);
    ent_valid[i]         = 1'b1;
    ent_ready[i]         = 1'b1;
    ent_class[i*2 +: 2]  = 2'(c);
    ent_age[i*6 +: 6]    = 6'(a);
  endtask

  task automatic set_free(input int alu, input int mul, input int br, input int mem);
    fu_free_cnt = {3'(mem), 3'(br), 3'(mul), 3'(alu)};
  endtask

  initial begin
    reset      = 1'b1;
    mispredict = 1'b0;
    out_ready  = 1'b1;
    head_age   = '0;
    clr_all();
    set_free(3, 3, 3, 3);
    set_ent(0, 0, 1);
    #2;
    check("reset_issue_valid", 64'(issue_valid), 64'h0);
    check("reset_issue_idx", 64'(issue_idx), 64'h0);
    check("reset_issue_class", 64'(issue_class), 64'h0);
    check("reset_clear_valid", 64'(clear_valid), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    clr_all();

    // basic
    set_ent(0, 0, 10); set_ent(1, 1, 20); set_ent(2, 0, 25); set_ent(3, 3, 30);
    #1;
    check("basic_clear_valid", 64'(clear_valid), 64'h7);
    check("basic_clear_idx", 64'(clear_idx), 64'h210);
    tick();
    check("basic_issue_valid", 64'(issue_valid), 64'h7);
    check("basic_issue_idx", 64'(issue_idx), 64'h210);
    check("basic_issue_class", 64'(issue_class), 64'h04);
    ent_valid[2:0] = 3'b000;
    #1;
    check("basic_rest_clear_valid", 64'(clear_valid), 64'h1);
    check("basic_rest_clear_idx", 64'(clear_idx), 64'h003);

    // class cap
    clr_all();
    set_ent(0, 0, 4); set_ent(1, 0, 3); set_ent(2, 0, 2); set_ent(3, 0, 1);
    set_ent(4, 1, 5);
    set_free(1, 3, 3, 3);
    #1;
    check("cap_clear_valid", 64'(clear_valid), 64'h3);
    check("cap_clear_idx", 64'(clear_idx), 64'h043);
    set_free(0, 3, 3, 3);
    #1;
    check("cap0_clear_valid", 64'(clear_valid), 64'h1);
    check("cap0_clear_idx", 64'(clear_idx), 64'h004);
    set_free(1, 3, 3, 3);
    tick();
    check("cap_issue_valid", 64'(issue_valid), 64'h3);
    check("cap_issue_idx", 64'(issue_idx), 64'h043);
    check("cap_issue_class", 64'(issue_class), 64'h04);

    // wrap-around, free counts above the issue width
    clr_all();
    head_age = 6'd60;
    set_free(7, 7, 7, 7);
    set_ent(0, 0, 5); set_ent(1, 0, 62); set_ent(2, 0, 1);
    #1;
    check("wrap_clear_valid", 64'(clear_valid), 64'h7);
    check("wrap_clear_idx", 64'(clear_idx), 64'h021);
    tick();
    check("wrap_issue_idx", 64'(issue_idx), 64'h021);
    check("wrap_issue_valid", 64'(issue_valid), 64'h7);

    // backpressure
    clr_all();
    head_age  = '0;
    out_ready = 1'b0;
    set_ent(8, 0, 1); set_ent(9, 0, 2); set_ent(10, 0, 3);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_clear_valid", 64'(clear_valid), 64'h0);
      tick();
      check("stall_issue_valid", 64'(issue_valid), 64'h7);
      check("stall_issue_idx", 64'(issue_idx), 64'h021);
    end
    out_ready = 1'b1;
    #1;
    check("release_clear_valid", 64'(clear_valid), 64'h7);
    check("release_clear_idx", 64'(clear_idx), 64'hA98);
    tick();
    check("release_issue_idx", 64'(issue_idx), 64'hA98);

    // mispredict while stalled
    clr_all();
    out_ready  = 1'b0;
    mispredict = 1'b1;
    set_ent(11, 0, 1); set_ent(12, 0, 2);
    #1;
    check("flush_clear_valid", 64'(clear_valid), 64'h0);
    tick();
    check("flush_issue_valid", 64'(issue_valid), 64'h0);
    mispredict = 1'b0;
    #1;
    check("empty_clear_valid", 64'(clear_valid), 64'h3);
    check("empty_clear_idx", 64'(clear_idx), 64'h0CB);
    tick();
    check("empty_issue_valid", 64'(issue_valid), 64'h3);
    check("empty_issue_idx", 64'(issue_idx), 64'h0CB);

    // no candidates
    clr_all();
    out_ready = 1'b1;
    #1;
    check("nocand_clear_valid", 64'(clear_valid), 64'h0);
    tick();
    check("nocand_issue_valid", 64'(issue_valid), 64'h0);

    // equal relative age: lower index first
    set_ent(5, 3, 7); set_ent(3, 3, 7);
    set_free(3, 3, 3, 3);
    #1;
    check("tie_clear_valid", 64'(clear_valid), 64'h3);
    check("tie_clear_idx", 64'(clear_idx), 64'h053);
    tick();
    check("tie_issue_class", 64'(issue_class), 64'h0F);

    // async reset mid-stall
    clr_all();
    set_ent(0, 0, 1); set_ent(1, 0, 2); set_ent(2, 0, 3);
    tick();
    check("prereset_issue_valid", 64'(issue_valid), 64'h7);
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("areset_issue_valid", 64'(issue_valid), 64'h0);
    check("areset_issue_idx", 64'(issue_idx), 64'h0);
    check("areset_clear_valid", 64'(clear_valid), 64'h0);
`ifdef ISSUE_PERF_CNT_EN
    check("areset_perf_issued", 64'(perf_issued), 64'h0);
    check("areset_perf_stall", 64'(perf_stall), 64'h0);
`endif
    tick();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/issue_select_pipe.md
Name: issue_select_pipe

Overview:
- Parametrised oldest-first issue selector between the reservation station (RS) and the FU issue register.
- Each cycle, picks up to ISSUE_W ready RS entries in wrap-aware ROB-age order, subject to per-FU-class free-unit counts.
- Drives same-cycle clear requests back to the RS and registers the grants into an issue register with a valid/ready handshake toward execute.
- Successor to the fixed 3-wide combinational issue stage: adds variable width, depth and class count, head-relative age, backpressure stall and mispredict flush.

Parameters:
- RS_DEPTH, 16, number of RS entries.
- ISSUE_W, 3, maximum grants per cycle.
- NUM_CLASS, 4, FU classes (ALU, MULT, BRANCH, MEM).
- AGE_W, 6, age width = {rob_wrap, rob_idx}.
- CNT_W, 3, width of per-class free-unit count.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mispredict  in  1  flush: suppress selection and invalidate the issue register
- ent_valid  in  RS_DEPTH  entry occupied
- ent_ready  in  RS_DEPTH  both operands ready
- ent_class  in  RS_DEPTH*$clog2(NUM_CLASS)  FU class per entry
- ent_age  in  RS_DEPTH*AGE_W  {rob_wrap, rob_idx} per entry
- head_age  in  AGE_W  ROB head age
- fu_free_cnt  in  NUM_CLASS*CNT_W  free units per class this cycle
- out_ready  in  1  execute accepts the issue register
- clear_valid  out  ISSUE_W  combinational clear request per slot
- clear_idx  out  ISSUE_W*$clog2(RS_DEPTH)  RS index to clear
- issue_valid  out  ISSUE_W  registered grant valid
- issue_idx  out  ISSUE_W*$clog2(RS_DEPTH)  registered RS index
- issue_class  out  ISSUE_W*$clog2(NUM_CLASS)  registered class

Behaviour:
- Reset (async): issue_valid=0, issue_idx=0, issue_class=0. clear_valid=0 while reset is high.
- Candidate: ent_valid & ent_ready & !mispredict.
- Relative age rel = (ent_age - head_age) mod 2^AGE_W. Smaller rel is older. Equal rel: lower index wins.
- Selection:
  - Candidates are granted in ascending rel order.
  - A candidate of class c is skipped once class c already holds fu_free_cnt[c] grants this cycle.
  - Stop at ISSUE_W grants.
  - Slot 0 = oldest grant; slots are filled contiguously from 0.
  - fu_free_cnt larger than ISSUE_W simply never limits.
- stall = |issue_valid & !out_ready.
- clear_valid[k] = grant[k] & !stall & !mispredict. clear_idx[k] = grant index (0 when not valid).
- Issue register update at posedge:
  - mispredict: issue_valid <= 0 (takes priority over stall).
  - else stall: hold all issue_* outputs.
  - else: load the grant vector, idx and class.
- Latency: one cycle from candidate to issue_valid. The RS clears at the same edge the grant is registered, so no entry is ever granted twice.
- Handshake: the register is consumed when out_ready=1 at a posedge. An empty register (issue_valid=0) loads regardless of out_ready.
- Wrap-around: head_age=60 with ages 62, 1, 5 (wrap bit flipped) yields order 62, 1, 5.
- No candidates: clear_valid=0; the register loads all-zero valid unless stalled.
- Reset mid-stall: the register clears immediately; there is no state other than the issue register.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined: two extra outputs, both async reset to 0 and wrapping at 2^32:
  - perf_issued (32b) adds popcount(clear_valid) each cycle.
  - perf_stall (32b) increments on each cycle with stall=1.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Basic: head_age=0; entries 0..3 ready with classes ALU, MULT, ALU, MEM and ages 10, 20, 25, 30; all free counts 3 -> clear_idx={0,1,2}, clear_valid=111; next cycle issue_idx={0,1,2}, issue_valid=111.
- Class cap: 4 ready ALU entries at ages 1..4; fu_free_cnt[ALU]=1, MULT ready at age 5 -> grants = ALU age1 idx, MULT idx, clear_valid=011.
- Wrap: head_age=60; ages 5, 62, 1 at idx 0, 1, 2 -> slot order idx 1, 2, 0.
- Backpressure: issue_valid=111 and out_ready=0 for 3 cycles -> clear_valid=000 and issue_* unchanged; out_ready=1 -> new grants load next edge.
- Mispredict while stalled with new candidates -> clear_valid=000; next edge issue_valid=000.
- Async reset asserted mid-cycle with issue_valid=111 -> issue_valid=000 before the next edge; with ISSUE_PERF_CNT_EN, perf_issued=0 and perf_stall=0.
